// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the matrix-multiply job sequencer.
// AW and EW are the widths for the default matrix size MM_N.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    COMPUTE,
    RD,
    OUT,
    DONE
  } mm_job_state_t;

  localparam int MM_N  = 4;
  localparam int MM_DW = 2;
  localparam int AW    = $clog2(MM_N);
  localparam int EW    = $clog2(MM_N * MM_N);

  // A dot product of N elements of width dw needs 2*dw bits plus log2(N) carry bits.
  function automatic int res_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mm_job_ctrl.sv
// Job sequencer: streams A then B into the bank write ports, starts the
// wrapper, waits out the compute window, then drains C row-major.
module mm_job_ctrl
  import mm_pkg::*;
#(
  parameter  int N           = MM_N,
  parameter  int DW          = MM_DW,
  parameter  int COMP_CYCLES = 2 * N + 4,
  localparam int RW          = res_width(DW, N),
  localparam int ADDR_W      = $clog2(N),
  localparam int ELEM_W      = $clog2(N * N),
  localparam int CYC_W       = $clog2(COMP_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_start,
  output logic                         busy,
  output logic                         done,
  input  logic [DW-1:0]                in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N-1:0][DW-1:0]         rom_mat_a_data,
  output logic [N-1:0][ADDR_W-1:0]     rom_mat_a_wr_addr,
  output logic [N-1:0]                 rom_mat_a_we,
  output logic [N-1:0][DW-1:0]         rom_mat_b_data,
  output logic [N-1:0][ADDR_W-1:0]     rom_mat_b_wr_addr,
  output logic [N-1:0]                 rom_mat_b_we,
  output logic                         mm_start,
  output logic [N-1:0][ADDR_W-1:0]     ram_rd_addr,
  input  logic [N-1:0][RW-1:0]         ram_data,
  output logic [RW-1:0]                res_data,
  output logic                         res_valid,
  input  logic                         res_ready
);

  mm_job_state_t       state_reg;
  logic [ELEM_W-1:0]   cnt_reg;
  logic [CYC_W-1:0]    cyc_reg;
  logic                in_ready_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                mm_start_reg;
  logic                res_valid_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;

  logic [1:0]          beat;
  logic [ADDR_W-1:0]   beat_bank;
  logic [ADDR_W-1:0]   beat_addr;
  logic [ADDR_W-1:0]   next_row;
  logic [ADDR_W-1:0]   res_col;
  logic                last_elem;
  logic                cyc_last;

  assign beat[0]   = (state_reg == LOAD_A) && in_valid && in_ready_reg;
  assign beat[1]   = (state_reg == LOAD_B) && in_valid && in_ready_reg;
  // A row-major and B column-major both map element k to bank k/N, address k%N.
  assign beat_bank = ADDR_W'(int'(cnt_reg) / N);
  assign beat_addr = ADDR_W'(int'(cnt_reg) % N);
  assign next_row  = ADDR_W'((int'(cnt_reg) + 1) / N);
  assign res_col   = ADDR_W'(int'(cnt_reg) % N);
  assign last_elem = (cnt_reg == ELEM_W'(N * N - 1));
  assign cyc_last  = (cyc_reg == CYC_W'(COMP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cyc_reg       <= '0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mm_start_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      rd_addr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (job_start) begin
            state_reg    <= LOAD_A;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
            cnt_reg      <= '0;
          end
        end
        LOAD_A: begin
          if (beat[0]) begin
            if (last_elem) begin
              cnt_reg   <= '0;
              state_reg <= LOAD_B;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (beat[1]) begin
            if (last_elem) begin
              cnt_reg      <= '0;
              in_ready_reg <= 1'b0;
              mm_start_reg <= 1'b1;
              state_reg    <= START;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        START: begin
          mm_start_reg <= 1'b0;
          cyc_reg      <= '0;
          state_reg    <= COMPUTE;
        end
        COMPUTE: begin
          if (cyc_last) begin
            cyc_reg     <= '0;
            rd_addr_reg <= '0;
            state_reg   <= RD;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        RD: begin
          res_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            if (last_elem) begin
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              cnt_reg     <= cnt_reg + 1'b1;
              rd_addr_reg <= next_row;
              state_reg   <= RD;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-port, per-bank write registers; port 0 is A, port 1 is B.
  genvar pi, gi;
  generate
    for (pi = 0; pi < 2; pi++) begin : g_port
      for (gi = 0; gi < N; gi++) begin : g_bank
        logic              we_reg;
        logic [ADDR_W-1:0] addr_reg;
        logic [DW-1:0]     data_reg;
        logic              hit;

        assign hit = beat[pi] && (beat_bank == ADDR_W'(gi));

        always_ff @(posedge clk) begin
          if (rst) begin
            we_reg   <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
          end else begin
            we_reg <= hit;
            if (hit) begin
              addr_reg <= beat_addr;
              data_reg <= in_data;
            end
          end
        end

        if (pi == 0) begin : g_a
          assign rom_mat_a_we[gi]      = we_reg;
          assign rom_mat_a_wr_addr[gi] = addr_reg;
          assign rom_mat_a_data[gi]    = data_reg;
        end else begin : g_b
          assign rom_mat_b_we[gi]      = we_reg;
          assign rom_mat_b_wr_addr[gi] = addr_reg;
          assign rom_mat_b_data[gi]    = data_reg;
        end
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_rd
      assign ram_rd_addr[gi] = rd_addr_reg;
    end
  endgenerate

  // The result RAM output is already registered and the address holds through OUT,
  // so the selected lane stays stable until the handshake.
  assign res_data  = res_valid_reg ? ram_data[res_col] : '0;
  assign res_valid = res_valid_reg;
  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mm_start  = mm_start_reg;

endmodule
